// File: rtl/sfq_pipelined_adder_nbit.sv
// Bit-level pipelined ripple-carry adder/subtractor: operands are skewed per bit, rippled
// through FA_LAT-stage full-adder slices, and deskewed so one word enters and leaves per cycle.
module sfq_pipelined_adder_nbit #(
    parameter int WIDTH  = 8,
    parameter int FA_LAT = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             sub,
    input  logic             cin,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int L = FA_LAT * WIDTH;

    // vld[d] is the valid of the word sitting at pipeline depth d (depth 0 = input register).
    logic [L:0]       vld;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] eb_r;
    logic             cin_r;
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum_bit;
    logic             ovf_msb;

    // NOTE: reset is synchronous, so it lives inside the clocked branch and every register
    // update uses <= so all stages sample the pre-edge values of their neighbours.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld   <= '0;
            a_r   <= '0;
            eb_r  <= '0;
            cin_r <= 1'b0;
        end else begin
            vld   <= {vld[L-1:0], in_valid};
            a_r   <= in_valid ? a : '0;
            eb_r  <= in_valid ? (sub ? ~b : b) : '0;
            cin_r <= in_valid & cin;
        end
    end

    assign carry[0] = cin_r;

    for (genvar i = 0; i < WIDTH; i++) begin : g_slice
        localparam int BASE = FA_LAT * i;
        localparam int DS   = FA_LAT * (WIDTH - 1 - i);

        logic              a_in;
        logic              b_in;
        logic [FA_LAT:1]   s_st;
        logic [FA_LAT:1]   c_st;

        // Entry skew: bit i waits until the carry from slice i-1 is ready.
        if (BASE > 0) begin : g_skew
            logic [BASE:1] a_d;
            logic [BASE:1] b_d;
            always_ff @(posedge clk) begin
                if (rst) begin
                    a_d <= '0;
                    b_d <= '0;
                end else begin
                    a_d[1] <= vld[0] ? a_r[i]  : 1'b0;
                    b_d[1] <= vld[0] ? eb_r[i] : 1'b0;
                    for (int j = 2; j <= BASE; j++) begin
                        a_d[j] <= vld[j-1] ? a_d[j-1] : 1'b0;
                        b_d[j] <= vld[j-1] ? b_d[j-1] : 1'b0;
                    end
                end
            end
            assign a_in = a_d[BASE];
            assign b_in = b_d[BASE];
        end else begin : g_noskew
            assign a_in = a_r[i];
            assign b_in = eb_r[i];
        end

        // Full-adder logic resolves into the first slice register; later stages carry it on.
        always_ff @(posedge clk) begin
            if (rst) begin
                s_st <= '0;
                c_st <= '0;
            end else begin
                s_st[1] <= vld[BASE] ? (a_in ^ b_in ^ carry[i]) : 1'b0;
                c_st[1] <= vld[BASE] ? ((a_in & b_in) | (carry[i] & (a_in ^ b_in))) : 1'b0;
                for (int m = 2; m <= FA_LAT; m++) begin
                    s_st[m] <= vld[BASE+m-1] ? s_st[m-1] : 1'b0;
                    c_st[m] <= vld[BASE+m-1] ? c_st[m-1] : 1'b0;
                end
            end
        end

        assign carry[i+1] = c_st[FA_LAT];

        // Signed overflow compares the carry into and out of the MSB, so only that slice needs it.
        if (i == WIDTH - 1) begin : g_ovf
            logic [FA_LAT:1] x_st;
            always_ff @(posedge clk) begin
                if (rst) begin
                    x_st <= '0;
                end else begin
                    x_st[1] <= vld[BASE]
                             ? (carry[i] ^ ((a_in & b_in) | (carry[i] & (a_in ^ b_in))))
                             : 1'b0;
                    for (int m = 2; m <= FA_LAT; m++) begin
                        x_st[m] <= vld[BASE+m-1] ? x_st[m-1] : 1'b0;
                    end
                end
            end
            assign ovf_msb = x_st[FA_LAT];
        end

        // Exit deskew: early sum bits wait for the MSB slice to finish.
        if (DS > 0) begin : g_deskew
            logic [DS:1] s_d;
            always_ff @(posedge clk) begin
                if (rst) begin
                    s_d <= '0;
                end else begin
                    s_d[1] <= vld[BASE+FA_LAT] ? s_st[FA_LAT] : 1'b0;
                    for (int k = 2; k <= DS; k++) begin
                        s_d[k] <= vld[BASE+FA_LAT+k-1] ? s_d[k-1] : 1'b0;
                    end
                end
            end
            assign sum_bit[i] = s_d[DS];
        end else begin : g_nodeskew
            assign sum_bit[i] = s_st[FA_LAT];
        end
    end

    assign out_valid = vld[L];
    assign sum       = sum_bit;
    assign cout      = carry[WIDTH];
    assign ovf       = ovf_msb;

endmodule

// File: tb/tb_sfq_pipelined_adder_nbit.sv
// Self-checking bench for sfq_pipelined_adder_nbit: arithmetic reference model indexed by exit edge,
// per-cycle compare process, and literal pins for the hand-computed cases.
module tb_sfq_pipelined_adder_nbit;
    localparam int W     = 8;
    localparam int FL    = 3;
    localparam int L     = W * FL;
    localparam int DEPTH = 4096;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         sub = 1'b0;
    logic         cin = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         out_valid;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    int n_cmp = 0;
    int n_bad = 0;

    sfq_pipelined_adder_nbit #(.WIDTH(W), .FA_LAT(FL)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .sub(sub), .cin(cin),
        .a(a), .b(b), .out_valid(out_valid), .sum(sum), .cout(cout), .ovf(ovf)
    );

    always #5 clk = ~clk;

    // Expected outputs, indexed by the edge after which they must be visible.
    bit         exp_v [DEPTH];
    bit [W-1:0] exp_s [DEPTH];
    bit         exp_c [DEPTH];
    bit         exp_o [DEPTH];
    int         ecount = 0;
    bit         armed  = 1'b0;

    function automatic bit [W+1:0] model(input bit [W-1:0] x, input bit [W-1:0] y,
                                         input bit c, input bit s);
        bit [W-1:0] ey;
        bit [W:0]   full;
        bit         o;
        ey   = s ? ~y : y;
        full = {1'b0, x} + {1'b0, ey} + {{W{1'b0}}, c};
        o    = (x[W-1] == ey[W-1]) && (full[W-1] != x[W-1]);
        return {o, full};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s at edge %0d: got %h expected %h", name, ecount - 1, got, want);
        end
    endtask

    always @(posedge clk) begin
        bit [W+1:0] r;
        if (rst) begin
            for (int j = 0; j <= L; j++) begin
                exp_v[ecount+j] = 1'b0;
                exp_s[ecount+j] = '0;
                exp_c[ecount+j] = 1'b0;
                exp_o[ecount+j] = 1'b0;
            end
            armed = 1'b1;
        end else begin
            r = in_valid ? model(a, b, cin, sub) : '0;
            exp_v[ecount+L] = in_valid;
            exp_s[ecount+L] = r[W-1:0];
            exp_c[ecount+L] = r[W];
            exp_o[ecount+L] = r[W+1];
        end
        ecount++;
    end

    always @(negedge clk) begin
        if (armed) begin
            check("out_valid", 32'(out_valid), 32'(exp_v[ecount-1]));
            check("sum",       32'(sum),       32'(exp_s[ecount-1]));
            check("cout",      32'(cout),      32'(exp_c[ecount-1]));
            check("ovf",       32'(ovf),       32'(exp_o[ecount-1]));
        end
    end

    task automatic drive(input bit r, input bit v, input bit [W-1:0] x, input bit [W-1:0] y,
                         input bit c, input bit s);
        @(negedge clk);
        rst = r; in_valid = v; a = x; b = y; cin = c; sub = s;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, W'($urandom), W'($urandom), 1'b0, 1'b0);
    endtask

    task automatic pin(input string name, input bit v, input bit [W-1:0] s,
                       input bit c, input bit o);
        check({name, ".out_valid"}, 32'(out_valid), 32'(v));
        check({name, ".sum"},       32'(sum),       32'(s));
        check({name, ".cout"},      32'(cout),      32'(c));
        check({name, ".ovf"},       32'(ovf),       32'(o));
    endtask

    initial begin
        // Reset with garbage valid words on both reset edges, then a quiet pipe.
        drive(1'b1, 1'b1, W'($urandom), W'($urandom), 1'b1, 1'b0);
        drive(1'b1, 1'b1, W'($urandom), W'($urandom), 1'b0, 1'b1);
        for (int i = 0; i < 30; i++) idle();
        pin("reset_quiet", 1'b0, 8'h00, 1'b0, 1'b0);

        drive(1'b0, 1'b1, 8'h5A, 8'h3C, 1'b0, 1'b0);
        idle();
        repeat (L) @(negedge clk);
        pin("single_add", 1'b1, 8'h96, 1'b0, 1'b1);
        @(negedge clk);
        pin("single_add_after", 1'b0, 8'h00, 1'b0, 1'b0);

        drive(1'b0, 1'b1, 8'hFF, 8'h00, 1'b1, 1'b0);
        idle();
        repeat (L) @(negedge clk);
        pin("full_ripple", 1'b1, 8'h00, 1'b1, 1'b0);

        drive(1'b0, 1'b1, 8'h10, 8'h20, 1'b1, 1'b1);
        drive(1'b0, 1'b1, 8'h80, 8'h01, 1'b1, 1'b1);
        idle();
        repeat (L - 1) @(negedge clk);
        pin("sub_borrow", 1'b1, 8'hF0, 1'b0, 1'b0);
        @(negedge clk);
        pin("sub_ovf", 1'b1, 8'h7F, 1'b1, 1'b1);

        // Streaming with one bubble at relative edge 10.
        for (int i = 0; i < 30; i++)
            drive(1'b0, (i != 10), W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
        idle();
        repeat (5) @(negedge clk);
        pin("stream_bubble", 1'b0, 8'h00, 1'b0, 1'b0);
        repeat (L) @(negedge clk);

        // Reset mid-flight: words at relative edges 0..3 are lost, 4 and 5 survive.
        for (int i = 0; i < 4; i++)
            drive((i == 3), 1'b1, W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
        drive(1'b0, 1'b1, 8'h01, 8'h02, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 8'h7F, 8'h01, 1'b0, 1'b0);
        idle();
        repeat (L - 5) @(negedge clk);
        pin("reset_mid_lost", 1'b0, 8'h00, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        pin("reset_mid_v4", 1'b1, 8'h03, 1'b0, 1'b0);
        @(negedge clk);
        pin("reset_mid_v5", 1'b1, 8'h80, 1'b0, 1'b1);

        // Long random run with sparse valid gaps and occasional resets.
        for (int i = 0; i < 400; i++)
            drive(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0),
                  W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
        for (int i = 0; i < L + 4; i++) idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
